// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch sequencer with DEPTH-entry prefetch queue
// Define IFQ_BYPASS_EN to forward the memory word straight to decode when the queue is empty.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcplus4
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   fpc_q, fpc_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_pc_q    [DEPTH];
  logic [31:0]   mem_pc_d    [DEPTH];
  logic [31:0]   mem_instr_q [DEPTH];
  logic [31:0]   mem_instr_d [DEPTH];

  logic [31:0] head_pc;
  logic [31:0] head_instr;
  logic        byp;
  logic        pop;
  logic        push;
  logic        q_wr;
  logic        q_rd;

  assign imem_addr = fpc_q & 32'hFFFF_FFFC;

  always_comb begin
    head_pc    = mem_pc_q[rptr_q];
    head_instr = mem_instr_q[rptr_q];
`ifdef IFQ_BYPASS_EN
    byp         = (count_q == '0) & ~redirect & ~reset;
    instr_valid = ~reset & ((count_q != '0) | byp);
`else
    byp         = 1'b0;
    instr_valid = (count_q != '0);
`endif
    instr   = byp ? imem_instr : head_instr;
    pc      = byp ? fpc_q : head_pc;
    pcplus4 = pc + 32'd4;
  end

  // A forwarded word that decode accepts is consumed without touching storage.
  always_comb begin
    pop  = instr_valid & ~stall;
    push = ~redirect & ((count_q != FULL_CNT) | pop);
    q_wr = push & ~(byp & pop);
    q_rd = pop & ~byp & ~redirect;
  end

  always_comb begin
    fpc_d       = fpc_q;
    rptr_d      = rptr_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
    if (redirect) begin
      fpc_d   = redirect_pc & 32'hFFFF_FFFC;
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        fpc_d = fpc_q + 32'd4;
      end
      if (q_wr) begin
        mem_pc_d[wptr_q]    = fpc_q;
        mem_instr_d[wptr_q] = imem_instr;
        wptr_d              = wptr_q + AW'(1);
      end
      if (q_rd) begin
        rptr_d = rptr_q + AW'(1);
      end
      case ({q_wr, q_rd})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q   <= RESET_PC;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      fpc_q       <= fpc_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
    end
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction-fetch sequencer and prefetch buffer sitting between the combinational-read instruction memory and the decode stage of the pipelined processor. It owns the fetch PC, presents a word-aligned address to the instruction memory every cycle, and captures returned words into a small FIFO. Decode drains the FIFO under a valid/stall handshake. Taken branches and jumps arrive as a redirect that flushes the queue and restarts fetch.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch PC after reset; bits [1:0] must be 0.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- imem_addr  out  32  fetch address to instruction memory; always word-aligned.
- imem_instr  in  32  word returned combinationally for imem_addr in the same cycle.
- stall  in  1  decode cannot accept this cycle.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored and treated as 0.
- instr_valid  out  1  instr/pc/pcplus4 hold a valid entry.
- instr  out  32  instruction at queue head.
- pc  out  32  address of instr.
- pcplus4  out  32  pc + 4, modulo 2^32.

## Operation
- State: fetch PC fpc, DEPTH-entry storage of {pc, instr}, read pointer rptr, write pointer wptr (log2 DEPTH bits, wrap modulo DEPTH), occupancy count (0..DEPTH).
- imem_addr = {fpc[31:2], 2'b00} continuously.
- pop = instr_valid & ~stall.
- push = ~redirect & ((count < DEPTH) | pop).
- On push: write {fpc, imem_instr} at wptr, wptr+1, fpc <= fpc + 4 (wraps from 32'hFFFF_FFFC to 0).
- On pop: rptr+1.
- count updates as +1 on push only, −1 on pop only, and is unchanged on both or neither.
- Redirect has priority over push and pop in the same cycle:
  - count <= 0, rptr <= wptr <= 0, fpc <= {redirect_pc[31:2], 2'b00}.
  - The head entry presented in the redirect cycle is dropped even if stall = 0; decode must squash it.
- Full (count = DEPTH): no push unless a pop occurs in the same cycle. fpc holds and imem_addr is stable.
- Empty (count = 0): instr_valid = 0; instr, pc and pcplus4 are don't-care but must not be X after reset.
- stall with instr_valid = 0 has no effect.
- Outputs come from the head entry (rptr), read combinationally from registered storage.

## Timing
- Reset values: fpc = RESET_PC, count = 0, rptr = wptr = 0, instr_valid = 0, storage cleared to 0, so instr = pc = 0 and pcplus4 = 4.
- Reset mid-operation discards all queued entries on the next edge, regardless of redirect or stall.
- Fetch-to-valid latency is 1 cycle. The word addressed in cycle N is presented at decode in cycle N+1 if the queue was empty.
- Redirect in cycle N:
  - imem_addr = redirect_pc in cycle N+1.
  - instr_valid = 0 in cycle N+1.
  - The first redirected instruction is valid in cycle N+2.
- Steady state with stall = 0: one instruction per cycle, pc advancing by 4 each cycle.
- After stall deasserts on a full queue, throughput resumes at 1 per cycle with no bubble.

## Configuration
- IFQ_BYPASS_EN defined:
  - When count = 0 and redirect = 0, outputs forward imem_instr / fpc directly and instr_valid = 1 in the same cycle.
  - If popped, the word is not written and fpc advances; if not popped, it is pushed normally.
  - Fetch-to-valid latency becomes 0 and redirect-to-valid becomes 1 cycle.
  - Reset still forces instr_valid = 0 during the reset cycle.
- IFQ_BYPASS_EN undefined: latencies exactly as in Timing.

## Test plan
- Reset release, RESET_PC = 0, stall = 0, memory word k = k:
  - instr_valid rises 1 cycle after reset deasserts.
  - pc = 0, 4, 8, … on consecutive cycles, with instr = 0, 1, 2, ….
- stall = 1 held for 6 cycles with DEPTH = 4:
  - count saturates at 4 and imem_addr freezes at 0x10.
  - On release, pc sequence continues 0x0, 0x4, … with no gaps or duplicates.
- redirect = 1 with redirect_pc = 0x43 while the queue holds 3 entries:
  - Next cycle: instr_valid = 0 and imem_addr = 0x40.
  - Following cycle: pc = 0x40.
- redirect and stall asserted in the same cycle on a full queue: queue empties, and the next valid pc is the redirect target, aligned.
- fpc at 0xFFFF_FFF8 with stall = 0: pc sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, and pcplus4 = 0 when pc = 0xFFFF_FFFC.
- With IFQ_BYPASS_EN, after reset release: instr_valid = 1 in the first cycle with pc = RESET_PC. After a redirect, valid is asserted 1 cycle later.
